// File: rtl/vga_pkg.sv
// Shared definitions for the VGA line-fetch controller: display defaults,
// line-buffer address widths and the fetch FSM state encoding.
package vga_pkg;

  localparam int H_DISP_DEF = 640;
  localparam int V_DISP_DEF = 480;

  localparam int BUF_IDX_W = 10;
  localparam int BUF_AW    = BUF_IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2,
    ST_NEXT  = 2'd3
  } fetch_state_e;

  // Line fetched at the end of row ypos; the last visible row wraps to line 0.
  function automatic logic [9:0] next_line(input logic [9:0] ypos, input int v_disp);
    if (ypos == 10'(v_disp - 1)) begin
      return 10'd0;
    end
    return ypos + 10'd1;
  endfunction

endpackage

// File: rtl/vga_line_fetch_ctrl_if.sv
// Burst-read bus between the line-fetch controller (master) and the
// memory arbiter (slave).
interface vga_line_fetch_ctrl_if #(
  parameter int AW = 24
) ();

  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_len;
  logic          rd_grant;
  logic          rd_valid;
  logic [23:0]   rd_data;

  modport master (
    output rd_req, rd_addr, rd_len,
    input  rd_grant, rd_valid, rd_data
  );

  modport slave (
    input  rd_req, rd_addr, rd_len,
    output rd_grant, rd_valid, rd_data
  );

endinterface

// File: rtl/vga_fetch_addr_gen.sv
// Burst start-address generator: a line-base accumulator stepped once per
// end-of-line event plus a burst-offset accumulator, so no multiplier is needed.
module vga_fetch_addr_gen
  import vga_pkg::*;
#(
  parameter int AW        = 24,
  parameter int H_DISP    = H_DISP_DEF,
  parameter int BURST_LEN = 64
) (
  input  logic          vga_clk,
  input  logic          sys_rst_n,
  input  logic          line_step_i,
  input  logic          line_wrap_i,
  input  logic [AW-1:0] frame_base_i,
  input  logic          fetch_start_i,
  input  logic          burst_next_i,
  output logic [AW-1:0] rd_addr_o
);

  logic [AW-1:0] line_base_q, line_base_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;

  // The base steps on every end-of-line, even a dropped one, so it keeps tracking the raster.
  always_comb begin
    line_base_d = line_base_q;
    if (line_step_i) begin
      line_base_d = line_wrap_i ? frame_base_i : line_base_q + AW'(H_DISP);
    end
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    if (fetch_start_i) begin
      rd_addr_d = line_base_d;
    end else if (burst_next_i) begin
      rd_addr_d = rd_addr_q + AW'(BURST_LEN);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      line_base_q <= '0;
      rd_addr_q   <= '0;
    end else begin
      line_base_q <= line_base_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign rd_addr_o = rd_addr_q;

endmodule

// File: rtl/vga_line_fetch_ctrl.sv
// Prefetches the next VGA line in bursts into one bank of a ping-pong line buffer.
// Define VGA_FETCH_UNDERRUN_EN to build the sticky late-trigger (underrun) flag.
module vga_line_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int H_DISP    = H_DISP_DEF,
  parameter int V_DISP    = V_DISP_DEF,
  parameter int BURST_LEN = 64,
  parameter int AW        = 24
) (
  input  logic                  vga_clk,
  input  logic                  sys_rst_n,
  input  logic [9:0]            pixel_xpos,
  input  logic [9:0]            pixel_ypos,
  input  logic [AW-1:0]         frame_base,
  vga_line_fetch_ctrl_if.master mem,
  output logic                  buf_wr_en,
  output logic [BUF_AW-1:0]     buf_wr_addr,
  output logic [23:0]           buf_wr_data,
  output logic                  buf_rd_bank,
  output logic                  fetch_busy,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int NUM_BURSTS = H_DISP / BURST_LEN;

  fetch_state_e         state_q, state_d;
  logic                 preload_q;
  logic [7:0]           beat_q, beat_d;
  logic [BUF_IDX_W-1:0] burst_q, burst_d;
  logic [BUF_IDX_W-1:0] idx_q, idx_d;
  logic                 bank_q, bank_d;
  logic                 wr_en_q, wr_en_d;
  logic [BUF_AW-1:0]    wr_addr_q, wr_addr_d;
  logic [23:0]          wr_data_q, wr_data_d;
  logic                 rd_bank_q;
  logic [AW-1:0]        rd_addr;

  logic       trigger, busy, start, beat, last_beat, last_burst;
  logic [9:0] target_line;

  assign trigger     = (pixel_xpos == 10'(H_DISP - 1)) && (pixel_ypos < 10'(V_DISP));
  assign busy        = (state_q != ST_IDLE);
  assign start       = !busy && (trigger || preload_q);
  assign target_line = preload_q ? 10'd0 : next_line(pixel_ypos, V_DISP);
  assign beat        = (state_q == ST_BURST) && mem.rd_valid;
  assign last_beat   = (beat_q == 8'(BURST_LEN - 1));
  assign last_burst  = (burst_q == BUF_IDX_W'(NUM_BURSTS - 1));

  // Starting only from IDLE also drops a trigger that lands on the NEXT->IDLE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_REQ;
      ST_REQ:   if (mem.rd_grant) state_d = ST_BURST;
      ST_BURST: if (beat && last_beat) state_d = ST_NEXT;
      ST_NEXT:  state_d = last_burst ? ST_IDLE : ST_REQ;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_d    = beat_q;
    burst_d   = burst_q;
    idx_d     = idx_q;
    bank_d    = bank_q;
    wr_en_d   = beat;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start) begin
      beat_d  = '0;
      burst_d = '0;
      idx_d   = '0;
      bank_d  = target_line[0];
    end
    if (beat) begin
      beat_d    = last_beat ? 8'd0 : beat_q + 8'd1;
      idx_d     = idx_q + BUF_IDX_W'(1);
      wr_addr_d = {bank_q, idx_q};
      wr_data_d = mem.rd_data;
    end
    if (state_q == ST_NEXT) begin
      burst_d = burst_q + BUF_IDX_W'(1);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      preload_q <= 1'b1;
      beat_q    <= '0;
      burst_q   <= '0;
      idx_q     <= '0;
      bank_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      preload_q <= 1'b0;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      idx_q     <= idx_d;
      bank_q    <= bank_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_bank_q <= pixel_ypos[0];
    end
  end

  vga_fetch_addr_gen #(
    .AW        (AW),
    .H_DISP    (H_DISP),
    .BURST_LEN (BURST_LEN)
  ) u_addr_gen (
    .vga_clk       (vga_clk),
    .sys_rst_n     (sys_rst_n),
    .line_step_i   (trigger || preload_q),
    .line_wrap_i   (target_line == 10'd0),
    .frame_base_i  (frame_base),
    .fetch_start_i (start),
    .burst_next_i  (state_q == ST_NEXT),
    .rd_addr_o     (rd_addr)
  );

`ifdef VGA_FETCH_UNDERRUN_EN
  logic underrun_q;

  // A new trigger beats a simultaneous clear.
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      underrun_q <= 1'b0;
    end else if (trigger && busy) begin
      underrun_q <= 1'b1;
    end else if (underrun_clr) begin
      underrun_q <= 1'b0;
    end
  end

  assign underrun = underrun_q;
`else
  logic unused_clr;
  assign unused_clr = underrun_clr;
  assign underrun   = 1'b0;
`endif

  assign mem.rd_req   = (state_q == ST_REQ);
  assign mem.rd_addr  = rd_addr;
  assign mem.rd_len   = 8'(BURST_LEN);
  assign buf_wr_en    = wr_en_q;
  assign buf_wr_addr  = wr_addr_q;
  assign buf_wr_data  = wr_data_q;
  assign buf_rd_bank  = rd_bank_q;
  assign fetch_busy   = busy;

endmodule

// File: doc/vga_line_fetch_ctrl.md
VGA_LINE_FETCH_CTRL -- requirements
Module: vga_line_fetch_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_DISP, 640, active pixels per line.
- V_DISP, 480, active lines per frame.
- BURST_LEN, 64, pixels per memory read burst; H_DISP is an integer multiple of it.
- AW, 24, memory address width in pixels.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- vga_clk  in  1  pixel clock; the only clock.
- sys_rst_n  in  1  reset; synchronous, active-low.
- pixel_xpos  in  10  current pixel column from the VGA timing driver.
- pixel_ypos  in  10  current pixel row from the VGA timing driver.
- frame_base  in  AW  frame-buffer base address; sampled at each line-0 fetch start.
- rd_req  out  1  burst read request to the memory arbiter.
- rd_addr  out  AW  burst start address.
- rd_len  out  8  burst length, constant BURST_LEN.
- rd_grant  in  1  arbiter accepts the request.
- rd_valid  in  1  read data beat valid.
- rd_data  in  24  read data beat (RGB888).
- buf_wr_en  out  1  line-buffer write strobe.
- buf_wr_addr  out  11  line-buffer write address: {bank, index[9:0]}.
- buf_wr_data  out  24  line-buffer write data.
- buf_rd_bank  out  1  bank the display side reads.
- fetch_busy  out  1  high while a line fetch is in progress.
- underrun  out  1  sticky: a fetch did not complete in time.
- underrun_clr  in  1  clears underrun.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, BURST and NEXT.
- IDLE->REQ on a trigger.
- REQ->BURST on the cycle rd_grant=1.
- BURST->NEXT after BURST_LEN rd_valid beats.
- NEXT->REQ if bursts remain in the line; NEXT->IDLE otherwise.

REQ-004 Triggers SHALL fire on the cycle pixel_xpos==H_DISP-1 and pixel_ypos<V_DISP.
- Target line is pixel_ypos+1.
- Target wraps to 0 when pixel_ypos==V_DISP-1.

REQ-005 rd_req SHALL be high throughout REQ, with rd_addr and rd_len stable, and low in the cycle after rd_grant is sampled high.

REQ-006 rd_addr SHALL equal frame_base + line*H_DISP + burst*BURST_LEN, computed modulo 2^AW. It is produced by running accumulators; no multiplier.

REQ-007 Each rd_valid beat in BURST SHALL produce buf_wr_en=1 on the next cycle.
- buf_wr_data is rd_data registered.
- buf_wr_addr is {line[0], pixel index}.
- Latency is 1 cycle.

REQ-008 rd_valid outside BURST SHALL be ignored: no write, no count change.

REQ-009 buf_wr_addr index SHALL increment by 1 per beat from 0 to H_DISP-1 and return to 0 at fetch start.

REQ-010 buf_rd_bank SHALL equal pixel_ypos[0], registered (1-cycle latency).

REQ-011 fetch_busy SHALL be high in every state except IDLE.

REQ-012 A trigger arriving while fetch_busy=1:
- The trigger SHALL be dropped; the current fetch continues unchanged.
- With the underrun feature compiled in, underrun SHALL be set.

REQ-013 A trigger coincident with the NEXT->IDLE transition SHALL count as arriving while busy.

REQ-014 underrun_clr SHALL clear underrun. If set and clear coincide, set wins.

Reset
REQ-015 While sys_rst_n=0, at every vga_clk edge:
- state SHALL be IDLE.
- rd_req, buf_wr_en, fetch_busy, underrun, buf_rd_bank, rd_addr, buf_wr_addr and buf_wr_data SHALL be 0.
- rd_len SHALL be BURST_LEN.

REQ-016 Reset asserted mid-fetch SHALL abandon the fetch immediately, with no further buffer writes.

REQ-017 On the first cycle after reset release, a fetch of line 0 SHALL start automatically (preload).

Configuration
REQ-018 With macro VGA_FETCH_UNDERRUN_EN defined, REQ-012 detection and the sticky underrun flag SHALL be implemented. Without it, underrun SHALL be constant 0, underrun_clr ignored, and late triggers still dropped.

Structure
REQ-019 The shared package vga_pkg SHALL hold:
- H_DISP and V_DISP defaults.
- The FSM state encoding.
- The buffer-address width constant.

REQ-020 The address accumulator (line base plus burst offset) SHALL be the sub-module vga_fetch_addr_gen. All other logic is flat.

Verification
REQ-021 Reset release, frame_base=0x001000, immediate grant:
- First rd_addr is 0x001000.
- 10 bursts of 64 beats produce 640 writes to bank 0.

REQ-022 Trigger at x=639, y=5; arbiter grants after 7 cycles:
- rd_req is high for exactly 8 cycles.
- rd_addr=frame_base+6*640.
- Writes go to bank 0, index 0..639.

REQ-023 Trigger at x=639, y=479:
- Line 0 is fetched with the newly sampled frame_base.
- Writes go to bank 0.

REQ-024 Grant withheld so a fetch is still busy at the next trigger:
- The trigger is dropped.
- underrun=1 with VGA_FETCH_UNDERRUN_EN defined; stays 0 without it.
- underrun_clr=1 alone clears it.

REQ-025 Reset pulled low during burst 3 of a line:
- rd_req=0 and buf_wr_en=0 from the next edge.
- After release, the line-0 preload restarts at index 0.

REQ-026 rd_valid pulses while in IDLE or REQ: no buf_wr_en is produced.
